// File: rtl/micro_uart3_pkg.sv
// Shared definitions for the micro_uart3 CPU-bus arbiter: FSM states,
// register address codes and the default bus width.
package micro_uart3_pkg;

    localparam int DW_DEFAULT = 16;

    localparam logic ADDR_DATA = 1'b0;
    localparam logic ADDR_BAUD = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DONE  = 2'd2
    } arb_state_t;

endpackage

// File: rtl/micro_uart3_rr_pick.sv
// Two-way request picker. Remembers the last granted requester so that
// round-robin ties alternate; fixed_prio makes requester 0 win every tie.
module micro_uart3_rr_pick (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       fixed_prio,
    input  logic       take,
    output logic       winner
);

    logic last_grant;

    // Winner is only meaningful while at least one req is high.
    always_comb begin
        winner = 1'b0;
        if (req == 2'b10) begin
            winner = 1'b1;
        end else if (req == 2'b11) begin
            winner = fixed_prio ? 1'b0 : ~last_grant;
        end
    end

    // Reset to 1 so requester 0 takes the first tie.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant <= 1'b1;
        end else if (take) begin
            last_grant <= winner;
        end
    end

endmodule

// File: rtl/micro_uart3_bus_arb.sv
// Arbitrates two req/ack requesters onto the micro_uart3 CPU register bus,
// issuing one single-cycle read or write strobe per granted transaction.
module micro_uart3_bus_arb
    import micro_uart3_pkg::*;
#(
    parameter int DW         = DW_DEFAULT,
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          rq0_req,
    input  logic          rq0_write,
    input  logic          rq0_addr,
    input  logic [DW-1:0] rq0_wdata,
    output logic          rq0_ack,
    output logic [DW-1:0] rq0_rdata,
    input  logic          rq1_req,
    input  logic          rq1_write,
    input  logic          rq1_addr,
    input  logic [DW-1:0] rq1_wdata,
    output logic          rq1_ack,
    output logic [DW-1:0] rq1_rdata,
    output logic          data_select,
    output logic          baud_select,
    output logic          cpu_read,
    output logic          cpu_write,
    output logic [DW-1:0] cpu_wdata,
    input  logic [DW-1:0] cpu_rdata,
    output logic          busy
);

    arb_state_t    state, state_next;
    logic          take;
    logic          winner;
    logic          owner;
    logic          lat_write;
    logic          lat_addr;
    logic [DW-1:0] lat_wdata;

    micro_uart3_rr_pick u_pick (
        .clk        (clk),
        .reset      (reset),
        .req        ({rq1_req, rq0_req}),
        .fixed_prio (FIXED_PRIO),
        .take       (take),
        .winner     (winner)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Bus outputs decode straight from the state so an asynchronous reset
    // drops strobes, selects and acks without waiting for a clock edge.
    always_comb begin
        state_next  = state;
        take        = 1'b0;
        data_select = 1'b0;
        baud_select = 1'b0;
        cpu_read    = 1'b0;
        cpu_write   = 1'b0;
        rq0_ack     = 1'b0;
        rq1_ack     = 1'b0;
        busy        = 1'b0;
        case (state)
            ST_IDLE: begin
                if (rq0_req || rq1_req) begin
                    take       = 1'b1;
                    state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                busy        = 1'b1;
                data_select = (lat_addr == ADDR_DATA);
                baud_select = (lat_addr == ADDR_BAUD);
                cpu_write   = lat_write;
                cpu_read    = ~lat_write;
                state_next  = ST_DONE;
            end
            ST_DONE: begin
                busy       = 1'b1;
                rq0_ack    = ~owner;
                rq1_ack    = owner;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Winner's request is captured at grant, so later req changes are ignored.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner     <= 1'b0;
            lat_write <= 1'b0;
            lat_addr  <= 1'b0;
            lat_wdata <= '0;
        end else if (take) begin
            owner     <= winner;
            lat_write <= winner ? rq1_write : rq0_write;
            lat_addr  <= winner ? rq1_addr  : rq0_addr;
            lat_wdata <= winner ? rq1_wdata : rq0_wdata;
        end
    end

    assign cpu_wdata = lat_wdata;

    // Read data lands at the end of ISSUE and is held until that owner reads again.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rq0_rdata <= '0;
            rq1_rdata <= '0;
        end else if (state == ST_ISSUE && !lat_write) begin
            if (owner) begin
                rq1_rdata <= cpu_rdata;
            end else begin
                rq0_rdata <= cpu_rdata;
            end
        end
    end

endmodule

// File: tb/tb_micro_uart3_bus_arb.sv
// Randomized bench for micro_uart3_bus_arb: one instance per priority mode,
// checked against a timestamp-based transaction model.
module tb_micro_uart3_bus_arb;

    localparam int DW = 16;

    logic          clk;
    logic          reset;
    logic          rq0_req, rq0_write, rq0_addr;
    logic [DW-1:0] rq0_wdata;
    logic          rq1_req, rq1_write, rq1_addr;
    logic [DW-1:0] rq1_wdata;
    logic [DW-1:0] cpu_rdata;

    logic [1:0]    o_ack0, o_ack1, o_dsel, o_bsel, o_rd, o_wr, o_busy;
    logic [DW-1:0] o_rdata0 [2];
    logic [DW-1:0] o_rdata1 [2];
    logic [DW-1:0] o_wdata  [2];

    for (genvar d = 0; d < 2; d++) begin : g_dut
        micro_uart3_bus_arb #(.DW(DW), .FIXED_PRIO(d == 1)) u_dut (
            .clk         (clk),
            .reset       (reset),
            .rq0_req     (rq0_req),
            .rq0_write   (rq0_write),
            .rq0_addr    (rq0_addr),
            .rq0_wdata   (rq0_wdata),
            .rq0_ack     (o_ack0[d]),
            .rq0_rdata   (o_rdata0[d]),
            .rq1_req     (rq1_req),
            .rq1_write   (rq1_write),
            .rq1_addr    (rq1_addr),
            .rq1_wdata   (rq1_wdata),
            .rq1_ack     (o_ack1[d]),
            .rq1_rdata   (o_rdata1[d]),
            .data_select (o_dsel[d]),
            .baud_select (o_bsel[d]),
            .cpu_read    (o_rd[d]),
            .cpu_write   (o_wr[d]),
            .cpu_wdata   (o_wdata[d]),
            .cpu_rdata   (cpu_rdata),
            .busy        (o_busy[d])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cur      = 0;

    // Transaction model: when the strobe and ack of the current grant occur.
    int            cyc;
    int            strobe_cyc;
    int            ack_cyc;
    bit            last_grant;
    bit            m_owner, m_write, m_addr;
    logic [DW-1:0] exp_wdata;
    logic [DW-1:0] m_rdata [2];

    // Requester behaviour.
    bit            act [2];
    bit            pend [2];
    bit            force_start [2];
    bit            f_write [2];
    bit            f_addr [2];
    logic [DW-1:0] f_wdata [2];
    int            start_pct [2];
    int            keep_pct [2];
    int            viol_pct [2];
    bit            fix_rdata_en;
    logic [DW-1:0] fix_rdata;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("[TB] FAIL %s (mode %0d, cycle %0d): got %h, expected %h", tag, cur, cyc, got, exp);
    endtask

    task automatic drivePins;
        rq0_req   = act[0];
        rq0_write = f_write[0];
        rq0_addr  = f_addr[0];
        rq0_wdata = f_wdata[0];
        rq1_req   = act[1];
        rq1_write = f_write[1];
        rq1_addr  = f_addr[1];
        rq1_wdata = f_wdata[1];
    endtask

    task automatic setKnobs(input int s, input int k, input int v);
        for (int i = 0; i < 2; i++) begin
            start_pct[i] = s;
            keep_pct[i]  = k;
            viol_pct[i]  = v;
        end
    endtask

    task automatic newFields(input int k);
        f_write[k] = 1'($urandom_range(1));
        f_addr[k]  = 1'($urandom_range(1));
        f_wdata[k] = DW'($urandom);
    endtask

    task automatic modelReset;
        cyc        = 0;
        strobe_cyc = -10;
        ack_cyc    = -10;
        last_grant = 1'b1;
        exp_wdata  = '0;
        for (int i = 0; i < 2; i++) begin
            m_rdata[i]     = '0;
            act[i]         = 1'b0;
            pend[i]        = 1'b0;
            force_start[i] = 1'b0;
        end
    endtask

    task automatic sampleCheck;
        bit s, a;
        logic [6:0] exp_ctrl, got_ctrl;
        s = (cyc == strobe_cyc);
        a = (cyc == ack_cyc);
        exp_ctrl = {s && !m_write, s && m_write, s && !m_addr, s && m_addr,
                    s || a, a && !m_owner, a && m_owner};
        got_ctrl = {o_rd[cur], o_wr[cur], o_dsel[cur], o_bsel[cur],
                    o_busy[cur], o_ack0[cur], o_ack1[cur]};
        checkOutput("rd_wr_dsel_bsel_busy_ack0_ack1", 32'(got_ctrl), 32'(exp_ctrl));
        checkOutput("rq0_rdata", 32'(o_rdata0[cur]), 32'(m_rdata[0]));
        checkOutput("rq1_rdata", 32'(o_rdata1[cur]), 32'(m_rdata[1]));
        checkOutput("cpu_wdata", 32'(o_wdata[cur]), 32'(exp_wdata));
    endtask

    task automatic applyStimulus;
        for (int k = 0; k < 2; k++) begin
            if (cyc == ack_cyc && int'(m_owner) == k) begin
                pend[k] = 1'b0;
                if (act[k]) begin
                    if (int'($urandom_range(99)) < keep_pct[k]) newFields(k);
                    else act[k] = 1'b0;
                end
            end else if (pend[k] && act[k] && cyc == strobe_cyc && int'(m_owner) == k) begin
                if (int'($urandom_range(99)) < viol_pct[k]) act[k] = 1'b0;
            end else if (!act[k] && !pend[k]) begin
                if (force_start[k]) begin
                    act[k]         = 1'b1;
                    force_start[k] = 1'b0;
                end else if (int'($urandom_range(99)) < start_pct[k]) begin
                    act[k] = 1'b1;
                    newFields(k);
                end
            end
        end
        cpu_rdata = fix_rdata_en ? fix_rdata : DW'($urandom);
        if (cyc == strobe_cyc && !m_write) m_rdata[m_owner] = cpu_rdata;
        drivePins();
    endtask

    // Grant decision for the edge that ends this cycle, if the bus is free.
    task automatic arbitrate;
        bit w;
        if (cyc > ack_cyc && (act[0] || act[1])) begin
            if (act[0] && act[1]) w = (cur == 1) ? 1'b0 : !last_grant;
            else w = act[1];
            last_grant = w;
            m_owner    = w;
            m_write    = f_write[w];
            m_addr     = f_addr[w];
            exp_wdata  = f_wdata[w];
            strobe_cyc = cyc + 1;
            ack_cyc    = cyc + 2;
            pend[w]    = 1'b1;
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            cyc++;
            sampleCheck();
            applyStimulus();
            arbitrate();
        end
    endtask

    task automatic doReset;
        reset = 1'b1;
        modelReset();
        cpu_rdata = '0;
        drivePins();
        repeat (2) @(posedge clk);
        #1;
        sampleCheck();
        reset = 1'b0;
    endtask

    initial begin
        reset        = 1'b1;
        fix_rdata_en = 1'b0;
        fix_rdata    = '0;
        for (int i = 0; i < 2; i++) begin
            f_write[i] = 1'b0;
            f_addr[i]  = 1'b0;
            f_wdata[i] = '0;
        end
        setKnobs(0, 0, 0);

        cur = 0;
        doReset();
        f_write[0] = 1'b1; f_addr[0] = 1'b1; f_wdata[0] = 16'h0040;
        force_start[0] = 1'b1;
        step(6);

        f_write[1] = 1'b0; f_addr[1] = 1'b0; f_wdata[1] = 16'h1234;
        fix_rdata_en = 1'b1; fix_rdata = 16'h00A5;
        force_start[1] = 1'b1;
        step(2);
        fix_rdata_en = 1'b0;
        step(12);

        // Both requesters held high: round-robin alternation.
        setKnobs(0, 100, 0);
        force_start[0] = 1'b1; force_start[1] = 1'b1;
        newFields(0); newFields(1);
        step(19);
        setKnobs(0, 0, 0);
        step(8);

        // Fixed priority: requester 1 only wins once requester 0 lets go.
        cur = 1;
        doReset();
        setKnobs(0, 100, 0);
        force_start[0] = 1'b1; force_start[1] = 1'b1;
        newFields(0); newFields(1);
        step(19);
        keep_pct[0] = 0;
        step(6);
        setKnobs(0, 0, 0);
        step(6);

        // Reset asserted in the ISSUE cycle of a write.
        cur = 0;
        doReset();
        f_write[0] = 1'b1; f_addr[0] = 1'b0; f_wdata[0] = 16'hBEEF;
        force_start[0] = 1'b1;
        step(2);
        reset = 1'b1;
        #1;
        checkOutput("reset_cpu_write", 32'(o_wr[cur]), 32'd0);
        checkOutput("reset_busy", 32'(o_busy[cur]), 32'd0);
        checkOutput("reset_acks", 32'({o_ack0[cur], o_ack1[cur]}), 32'd0);
        doReset();
        step(6);
        newFields(0); newFields(1);
        force_start[0] = 1'b1; force_start[1] = 1'b1;
        step(8);

        // Requester drops req during ISSUE; ack must still arrive.
        doReset();
        f_write[0] = 1'b0; f_addr[0] = 1'b1; f_wdata[0] = 16'h0007;
        force_start[0] = 1'b1;
        viol_pct[0] = 100;
        step(8);
        viol_pct[0] = 0;

        // Randomized traffic in both priority modes.
        for (int m = 0; m < 2; m++) begin
            cur = m;
            doReset();
            setKnobs(35, 40, 5);
            step(700);
            setKnobs(0, 0, 0);
            step(6);
        end

        $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/micro_uart3_bus_arb.md
Name: micro_uart3_bus_arb

Overview:
- Shares the micro_uart3 CPU register bus between two independent requesters, for example the APB host and a hardware logger/DMA engine.
- Each requester runs a level req/ack handshake; the block arbitrates and issues exactly one single-cycle read or write strobe per granted transaction.
- On a read it captures the UART read data and returns it with the ack.
- Sits between the requesters and the micro_uart3 CPU-bus pins (data_select, baud_select, cpu_read, cpu_write, cpu_wdata, cpu_rdata).

Parameters:
- DW, 16, register data width; matches the micro_uart3 cpu_wdata/cpu_rdata width.
- FIXED_PRIO, 0, 0 = round-robin between requesters; 1 = requester 0 always wins a tie.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- rq0_req  input  1  requester 0 transaction request (level)
- rq0_write  input  1  1 = write, 0 = read
- rq0_addr  input  1  0 = data register, 1 = baud register
- rq0_wdata  input  DW  write data
- rq0_ack  output  1  single-cycle completion pulse
- rq0_rdata  output  DW  read data, valid when rq0_ack is high, held afterwards
- rq1_req, rq1_write, rq1_addr, rq1_wdata, rq1_ack, rq1_rdata  same as requester 0
- data_select  output  1  to UART: data register selected
- baud_select  output  1  to UART: baud register selected
- cpu_read  output  1  to UART: read strobe
- cpu_write  output  1  to UART: write strobe
- cpu_wdata  output  DW  to UART: write data
- cpu_rdata  input  DW  from UART: combinational read data
- busy  output  1  high in ISSUE and DONE

Behaviour:
- Reset values: all outputs 0; state = IDLE; last_grant = 1, so requester 0 wins the first tie.
- FSM states: IDLE, ISSUE, DONE.
- IDLE:
  - If no req is high, stay in IDLE.
  - Otherwise pick a winner and latch its write, addr and wdata into registers, plus the owner id. Go to ISSUE.
- Winner selection:
  - Only one req high: that requester wins.
  - Both high, FIXED_PRIO = 0: the requester that is not last_grant wins.
  - Both high, FIXED_PRIO = 1: requester 0 wins.
  - last_grant updates to the winner.
- ISSUE (exactly 1 cycle):
  - data_select = (latched addr == 0); baud_select = (latched addr == 1); cpu_wdata = latched wdata.
  - Exactly one of cpu_write / cpu_read is high, according to latched write.
  - On a read, cpu_rdata is captured at the end of this cycle into the owner's rdata register.
  - Always go to DONE.
- ISSUE outputs: selects and strobes are 0 outside ISSUE; cpu_wdata holds its last value.
- DONE (1 cycle): owner's ack = 1, then go to IDLE.
  - A read's rdata is visible in the same cycle as ack.
  - rdata is unchanged after a write and holds until that requester's next read.
- Latency: req first seen high at edge N → strobe in cycle N+1 → ack in cycle N+2. Minimum 3 cycles per transaction.
- Handshake rules:
  - A requester holds req, write, addr and wdata stable until it sees ack.
  - It drops req at the edge that ends the ack cycle, or keeps req high to request a new transaction.
  - Inputs are sampled only in IDLE.
- Back-to-back traffic: with both reqs held high in round-robin mode, grants alternate 0, 1, 0, 1 …
- req dropped mid-transaction (protocol violation): the transaction still completes and ack is still pulsed.
- Reset asserted mid-transaction:
  - Strobes, selects, acks and busy clear immediately (asynchronous).
  - The FSM returns to IDLE and last_grant returns to 1.
  - No strobe is issued after reset releases unless a req is high.
- Never assert cpu_read and cpu_write together; never assert both acks together.
- The UART irq does not pass through this block.

Decomposition:
- micro_uart3_pkg: FSM state encoding (IDLE/ISSUE/DONE), ADDR_DATA = 0, ADDR_BAUD = 1, DW default.
- One natural sub-module, micro_uart3_rr_pick: 2-way picker holding last_grant; inputs req[1:0], fixed_prio, take; outputs winner.

Test Plan:
- Reset, then rq0 write addr 1, wdata 16'h0040 → cycle +1: baud_select = 1 and cpu_write = 1 with cpu_wdata = 16'h0040 for one cycle; cycle +2: rq0_ack = 1 for one cycle; busy = 1 for 2 cycles.
- rq1 read addr 0 with cpu_rdata driven to 16'h00A5 → cpu_read pulses once with data_select = 1; rq1_ack and rq1_rdata = 16'h00A5 in the next cycle; rq1_rdata still 16'h00A5 after 10 idle cycles.
- Both reqs held high for 6 transactions, FIXED_PRIO = 0 → grant order 0, 1, 0, 1, 0, 1; one strobe per 3 cycles; acks never overlap.
- Same stimulus with FIXED_PRIO = 1 → all grants to rq0; rq1 acked only after rq0_req drops.
- Assert reset during the ISSUE cycle of a write → cpu_write falls in the same cycle; no ack is issued; after release with reqs low, the bus stays idle; the first later tie goes to rq0.
- rq0 drops req during ISSUE → rq0_ack is still pulsed in the DONE cycle; the block then returns to IDLE with no extra strobe.
